// File: rtl/asip_pkg.sv
// rtl/asip_pkg.sv - shared widths and the writeback entry type for the ASIP datapath
package asip_pkg;
  localparam int DATA_W = 18;
  localparam int ADDR_W = 4;
  localparam logic [ADDR_W-1:0] PC_REG = 4'd15;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_lq_fifo.sv
// rtl/wb_lq_fifo.sv - load-response FIFO of writeback entries
module wb_lq_fifo
  import asip_pkg::*;
#(
  parameter int LQ_DEPTH = 4,
  parameter int PTR_W    = $clog2(LQ_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  wb_entry_t        push_entry,
  input  logic             pop,
  output wb_entry_t        head,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);
  wb_entry_t        mem_q [LQ_DEPTH];
  wb_entry_t        mem_d [LQ_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (PTR_W+1)'(LQ_DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    // Pointers wrap naturally because the depth is a power of two.
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LQ_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/wb_unit.sv
// rtl/wb_unit.sv - writeback unit: merges ALU results and load responses onto the
// register-file write port, redirects R15 writes to the PC, tracks pending loads.
module wb_unit
  import asip_pkg::*;
#(
  parameter int LQ_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              ld_issue,
  input  logic [ADDR_W-1:0] ld_issue_rd,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_rd,
  input  logic [DATA_W-1:0] ld_data,
  output logic              we3,
  output logic [ADDR_W-1:0] wa3,
  output logic [DATA_W-1:0] wd3,
  output logic              pc_we,
  output logic [DATA_W-1:0] pc_wd,
  output logic [14:0]       busy,
  output logic              lq_ovf
);
  localparam int PTR_W = $clog2(LQ_DEPTH);

  logic              we3_q, we3_d;
  logic [ADDR_W-1:0] wa3_q, wa3_d;
  logic [DATA_W-1:0] wd3_q, wd3_d;
  logic              pc_we_q, pc_we_d;
  logic [DATA_W-1:0] pc_wd_q, pc_wd_d;
  logic [14:0]       busy_q, busy_d;
  logic              lq_ovf_q, lq_ovf_d;

  wb_entry_t      push_entry, head, sel;
  logic [PTR_W:0] lq_count;
  logic           lq_full, lq_empty;
  logic           push, pop, sel_valid;

  assign ld_ready   = !lq_full;
  assign push       = ld_valid && ld_ready;
  assign pop        = !alu_valid && !lq_empty;
  assign push_entry = '{rd: ld_rd, data: ld_data};

  wb_lq_fifo #(.LQ_DEPTH(LQ_DEPTH)) u_lq (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (lq_count),
    .full       (lq_full),
    .empty      (lq_empty)
  );

  always_comb begin
    sel       = alu_valid ? '{rd: alu_rd, data: alu_data} : head;
    sel_valid = alu_valid || !lq_empty;
    we3_d     = 1'b0;
    wa3_d     = wa3_q;
    wd3_d     = wd3_q;
    pc_we_d   = 1'b0;
    pc_wd_d   = pc_wd_q;
    if (sel_valid) begin
      if (sel.rd == PC_REG) begin
        pc_we_d = 1'b1;
        pc_wd_d = sel.data;
      end else begin
        we3_d = 1'b1;
        wa3_d = sel.rd;
        wd3_d = sel.data;
      end
    end
  end

  // Clear before set so an issue to the register being popped keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (pop && head.rd != PC_REG) begin
      busy_d[head.rd] = 1'b0;
    end
    if (ld_issue && ld_issue_rd != PC_REG) begin
      busy_d[ld_issue_rd] = 1'b1;
    end
    lq_ovf_d = lq_ovf_q || (ld_valid && !ld_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we3_q    <= 1'b0;
      wa3_q    <= '0;
      wd3_q    <= '0;
      pc_we_q  <= 1'b0;
      pc_wd_q  <= '0;
      busy_q   <= '0;
      lq_ovf_q <= 1'b0;
    end else begin
      we3_q    <= we3_d;
      wa3_q    <= wa3_d;
      wd3_q    <= wd3_d;
      pc_we_q  <= pc_we_d;
      pc_wd_q  <= pc_wd_d;
      busy_q   <= busy_d;
      lq_ovf_q <= lq_ovf_d;
    end
  end

  assign we3    = we3_q;
  assign wa3    = wa3_q;
  assign wd3    = wd3_q;
  assign pc_we  = pc_we_q;
  assign pc_wd  = pc_wd_q;
  assign busy   = busy_q;
  assign lq_ovf = lq_ovf_q;
endmodule

// File: tb/tb_wb_unit.sv
// tb/tb_wb_unit.sv - directed self-checking bench for wb_unit
module tb_wb_unit;
  logic        clk;
  logic        rst_n;
  logic        alu_valid;
  logic [3:0]  alu_rd;
  logic [17:0] alu_data;
  logic        ld_issue;
  logic [3:0]  ld_issue_rd;
  logic        ld_valid;
  logic        ld_ready;
  logic [3:0]  ld_rd;
  logic [17:0] ld_data;
  logic        we3;
  logic [3:0]  wa3;
  logic [17:0] wd3;
  logic        pc_we;
  logic [17:0] pc_wd;
  logic [14:0] busy;
  logic        lq_ovf;

  int n_cmp = 0;
  int n_err = 0;

  wb_unit #(.LQ_DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .ld_issue    (ld_issue),
    .ld_issue_rd (ld_issue_rd),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_rd       (ld_rd),
    .ld_data     (ld_data),
    .we3         (we3),
    .wa3         (wa3),
    .wd3         (wd3),
    .pc_we       (pc_we),
    .pc_wd       (pc_wd),
    .busy        (busy),
    .lq_ovf      (lq_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    alu_valid   = 1'b0;
    alu_rd      = '0;
    alu_data    = '0;
    ld_issue    = 1'b0;
    ld_issue_rd = '0;
    ld_valid    = 1'b0;
    ld_rd       = '0;
    ld_data     = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    chk("rst_we3", we3, 0);
    chk("rst_wa3", wa3, 0);
    chk("rst_wd3", wd3, 0);
    chk("rst_pc_we", pc_we, 0);
    chk("rst_pc_wd", pc_wd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", lq_ovf, 0);
    chk("rst_ready", ld_ready, 1);
    rst_n = 1'b1;
    tick();

    // ALU write to R3
    alu_valid = 1'b1; alu_rd = 4'd3; alu_data = 18'h2A5A;
    tick();
    idle_inputs();
    chk("alu_we3", we3, 1);
    chk("alu_wa3", wa3, 3);
    chk("alu_wd3", wd3, 18'h2A5A);
    tick();
    chk("alu_we3_drop", we3, 0);
    chk("alu_wa3_hold", wa3, 3);
    chk("alu_wd3_hold", wd3, 18'h2A5A);

    // ALU priority over a queued load
    ld_issue = 1'b1; ld_issue_rd = 4'd5;
    tick();
    idle_inputs();
    chk("prio_busy_set", busy, 15'h0020);
    ld_valid = 1'b1; ld_rd = 4'd5; ld_data = 18'h00111;
    alu_valid = 1'b1; alu_rd = 4'd2; alu_data = 18'h00ABC;
    tick();
    idle_inputs();
    chk("prio_alu_we3", we3, 1);
    chk("prio_alu_wa3", wa3, 2);
    chk("prio_alu_wd3", wd3, 18'h00ABC);
    chk("prio_busy_held", busy, 15'h0020);
    tick();
    chk("prio_ld_we3", we3, 1);
    chk("prio_ld_wa3", wa3, 5);
    chk("prio_ld_wd3", wd3, 18'h00111);
    chk("prio_busy_clr", busy, 0);
    tick();
    chk("prio_idle_we3", we3, 0);

    // PC redirect from the ALU
    alu_valid = 1'b1; alu_rd = 4'd15; alu_data = 18'h00040;
    tick();
    idle_inputs();
    chk("pc_we", pc_we, 1);
    chk("pc_wd", pc_wd, 18'h00040);
    chk("pc_no_we3", we3, 0);
    chk("pc_wa3_hold", wa3, 5);
    tick();
    chk("pc_we_drop", pc_we, 0);
    chk("pc_wd_hold", pc_wd, 18'h00040);

    // R15 issue is not tracked; a load to R15 redirects the PC
    ld_issue = 1'b1; ld_issue_rd = 4'd15;
    ld_valid = 1'b1; ld_rd = 4'd15; ld_data = 18'h3FFFF;
    tick();
    idle_inputs();
    chk("r15_busy", busy, 0);
    chk("r15_push_no_pc", pc_we, 0);
    tick();
    chk("r15_ld_pc_we", pc_we, 1);
    chk("r15_ld_pc_wd", pc_wd, 18'h3FFFF);
    chk("r15_ld_no_we3", we3, 0);
    tick();

    // FIFO full under continuous ALU traffic
    for (int i = 0; i < 5; i++) begin
      alu_valid = 1'b1; alu_rd = 4'd1; alu_data = 18'(32'h200 + i);
      ld_valid = 1'b1; ld_rd = 4'(8 + i); ld_data = 18'(32'h100 + i);
      chk($sformatf("full_ready_%0d", i), ld_ready, (i < 4) ? 1 : 0);
      tick();
      chk($sformatf("full_alu_wd3_%0d", i), wd3, 32'h200 + i);
    end
    idle_inputs();
    chk("full_ovf", lq_ovf, 1);
    chk("full_alu_wa3", wa3, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("drain_we3_%0d", i), we3, 1);
      chk($sformatf("drain_wa3_%0d", i), wa3, 8 + i);
      chk($sformatf("drain_wd3_%0d", i), wd3, 32'h100 + i);
    end
    tick();
    chk("drain_idle_we3", we3, 0);
    chk("drain_ready", ld_ready, 1);
    chk("ovf_sticky", lq_ovf, 1);

    // Scoreboard: set wins over same-cycle pop clear
    ld_issue = 1'b1; ld_issue_rd = 4'd7;
    tick();
    idle_inputs();
    chk("sb_busy_set", busy, 15'h0080);
    ld_valid = 1'b1; ld_rd = 4'd7; ld_data = 18'h00077;
    tick();
    idle_inputs();
    chk("sb_push_no_we3", we3, 0);
    ld_issue = 1'b1; ld_issue_rd = 4'd7;
    tick();
    idle_inputs();
    chk("sb_pop_we3", we3, 1);
    chk("sb_pop_wa3", wa3, 7);
    chk("sb_pop_wd3", wd3, 18'h00077);
    chk("sb_set_wins", busy, 15'h0080);
    ld_valid = 1'b1; ld_rd = 4'd7; ld_data = 18'h00078;
    tick();
    idle_inputs();
    tick();
    chk("sb_second_clr", busy, 0);
    chk("sb_second_wd3", wd3, 18'h00078);

    // Asynchronous reset with two entries queued
    alu_valid = 1'b1; alu_rd = 4'd1; alu_data = 18'h00001;
    ld_issue = 1'b1; ld_issue_rd = 4'd4;
    ld_valid = 1'b1; ld_rd = 4'd4; ld_data = 18'h00AAA;
    tick();
    ld_issue = 1'b0;
    ld_rd = 4'd6; ld_data = 18'h00BBB;
    tick();
    chk("pre_rst_busy", busy, 15'h0010);
    rst_n = 1'b0;
    #1;
    idle_inputs();
    chk("arst_we3", we3, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", ld_ready, 1);
    chk("arst_ovf", lq_ovf, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("post_rst_we3_%0d", i), we3, 0);
      chk($sformatf("post_rst_pc_we_%0d", i), pc_we, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
